fp_minmax_stream: RTL and testbench

- Streaming, parametrised successor to the combinational FP comparator.
- Accepts one IEEE-754 operand per cycle over a valid/ready stream.
- Tracks the running minimum and maximum, with the index of each, across a frame delimited by in_last.
- Emits one result record per frame over a second valid/ready stream. Used ahead of normalisation/scaling blocks that need per-frame range.

---
 rtl/fp_minmax_pkg.sv | 27 ++
 rtl/fp_order_key.sv | 50 +++++
 rtl/fp_minmax_stream.sv | 122 ++++++++++++
 tb/tb_fp_minmax_stream.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_minmax_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_minmax_pkg
// Description : Shared state encoding and field-width constants for the
//               streaming FP min/max tracker.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_minmax_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int C_DEF_SIG_WIDTH = 23;
    localparam int C_DEF_EXP_WIDTH = 8;
    localparam int C_DEF_MAX_FRAME = 256;

    localparam int C_TOTAL_WIDTH = C_DEF_SIG_WIDTH + C_DEF_EXP_WIDTH + 1;
    localparam int C_KEY_WIDTH   = C_DEF_SIG_WIDTH + C_DEF_EXP_WIDTH + 1;
    localparam int C_IDX_W       = $clog2(C_DEF_MAX_FRAME);

    localparam logic [C_DEF_EXP_WIDTH-1:0] C_EXP_ONES  = '1;
    localparam logic [C_DEF_EXP_WIDTH-1:0] C_EXP_ZEROS = '0;

endpackage : fp_minmax_pkg
`default_nettype wire

// File: rtl/fp_order_key.sv
`default_nettype none
// ============================================================================
// Module      : fp_order_key
// Description : Maps an IEEE-754 operand onto a signed integer key whose
//               ordering matches the numeric ordering of the operand.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_order_key
    import fp_minmax_pkg::*;
#(
    parameter int SIG_WIDTH = C_DEF_SIG_WIDTH,
    parameter int EXP_WIDTH = C_DEF_EXP_WIDTH
) (
    input  logic [SIG_WIDTH+EXP_WIDTH:0]        in_data,
    input  logic                                ieee_compliance,
    output logic signed [SIG_WIDTH+EXP_WIDTH:0] key,
    output logic                                is_nan
);

    localparam int C_TW = SIG_WIDTH + EXP_WIDTH + 1;

    logic                 w_sign;
    logic [EXP_WIDTH-1:0] w_exp;
    logic [SIG_WIDTH-1:0] w_frac;
    logic [C_TW-2:0]      w_mag;

    assign w_sign = in_data[C_TW-1];
    assign w_exp  = in_data[C_TW-2 -: EXP_WIDTH];
    assign w_frac = in_data[SIG_WIDTH-1:0];

    // Exponent:fraction is already monotonic in magnitude; only the special
    // encodings need remapping before the sign is applied.
    always_comb begin
        w_mag  = in_data[C_TW-2:0];
        is_nan = 1'b0;
        if (&w_exp) begin
            if (!ieee_compliance) begin
                w_mag = {w_exp, {SIG_WIDTH{1'b0}}};
            end else if (|w_frac) begin
                is_nan = 1'b1;
                w_mag  = '0;
            end
        end else if (~|w_exp && !ieee_compliance) begin
            w_mag = '0;
        end
        key = w_sign ? -$signed({1'b0, w_mag}) : $signed({1'b0, w_mag});
    end

endmodule : fp_order_key
`default_nettype wire

// File: rtl/fp_minmax_stream.sv
`default_nettype none
// ============================================================================
// Module      : fp_minmax_stream
// Description : Streams FP operands, tracks per-frame min/max with indices,
//               and emits one result record per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_minmax_stream
    import fp_minmax_pkg::*;
#(
    parameter int SIG_WIDTH       = C_DEF_SIG_WIDTH,
    parameter int EXP_WIDTH       = C_DEF_EXP_WIDTH,
    parameter int IEEE_COMPLIANCE = 0,
    parameter int MAX_FRAME       = C_DEF_MAX_FRAME
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [SIG_WIDTH+EXP_WIDTH:0]      in_data,
    input  logic                              in_last,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [SIG_WIDTH+EXP_WIDTH:0]      out_min,
    output logic [SIG_WIDTH+EXP_WIDTH:0]      out_max,
    output logic [$clog2(MAX_FRAME)-1:0]      out_min_idx,
    output logic [$clog2(MAX_FRAME)-1:0]      out_max_idx,
    output logic [$clog2(MAX_FRAME):0]        out_count,
    output logic                              out_nan,
    output logic                              out_trunc
);

    localparam int                C_TW        = SIG_WIDTH + EXP_WIDTH + 1;
    localparam int                C_IW        = $clog2(MAX_FRAME);
    localparam logic [C_IW:0]     C_MAX_COUNT = (C_IW + 1)'(MAX_FRAME);
    localparam logic              C_IEEE      = (IEEE_COMPLIANCE != 0);

    state_t                  r_state;
    logic signed [C_TW-1:0]  r_min_key;
    logic signed [C_TW-1:0]  r_max_key;
    logic [C_TW-1:0]         r_min;
    logic [C_TW-1:0]         r_max;
    logic [C_IW-1:0]         r_min_idx;
    logic [C_IW-1:0]         r_max_idx;
    logic [C_IW:0]           r_count;
    logic                    r_have;
    logic                    r_nan;
    logic                    r_trunc;

    logic signed [C_TW-1:0]  w_key;
    logic                    w_is_nan;
    logic                    w_accept;
    logic [C_IW:0]           w_count_nxt;
    logic [C_IW-1:0]         w_idx;

    fp_order_key #(
        .SIG_WIDTH (SIG_WIDTH),
        .EXP_WIDTH (EXP_WIDTH)
    ) u_order_key (
        .in_data         (in_data),
        .ieee_compliance (C_IEEE),
        .key             (w_key),
        .is_nan          (w_is_nan)
    );

    assign w_accept    = in_valid && (r_state == ACCUM);
    assign w_count_nxt = r_count + 1'b1;
    assign w_idx       = r_count[C_IW-1:0];

    // The handshake in HOLD clears everything exactly like reset, which also
    // gives the mandated one-cycle bubble before the next frame.
    always_ff @(posedge clk) begin
        if (rst || (r_state == HOLD && out_ready)) begin
            r_state   <= ACCUM;
            r_min_key <= '0;
            r_max_key <= '0;
            r_min     <= '0;
            r_max     <= '0;
            r_min_idx <= '0;
            r_max_idx <= '0;
            r_count   <= '0;
            r_have    <= 1'b0;
            r_nan     <= 1'b0;
            r_trunc   <= 1'b0;
        end else if (w_accept) begin
            r_count <= w_count_nxt;
            if (w_is_nan) begin
                r_nan <= 1'b1;
            end else begin
                if (!r_have || w_key < r_min_key) begin
                    r_min_key <= w_key;
                    r_min     <= in_data;
                    r_min_idx <= w_idx;
                end
                if (!r_have || w_key > r_max_key) begin
                    r_max_key <= w_key;
                    r_max     <= in_data;
                    r_max_idx <= w_idx;
                end
                r_have <= 1'b1;
            end
            if (in_last) begin
                r_state <= HOLD;
            end else if (w_count_nxt == C_MAX_COUNT) begin
                r_state <= HOLD;
                r_trunc <= 1'b1;
            end
        end
    end

    assign in_ready    = (r_state == ACCUM);
    assign out_valid   = (r_state == HOLD);
    assign out_min     = r_min;
    assign out_max     = r_max;
    assign out_min_idx = r_min_idx;
    assign out_max_idx = r_max_idx;
    assign out_count   = r_count;
    assign out_nan     = r_nan;
    assign out_trunc   = r_trunc;

endmodule : fp_minmax_stream
`default_nettype wire

// File: tb/tb_fp_minmax_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_minmax_stream
// Description : Directed self-checking bench; three instances cover default
//               compliance, full IEEE handling and a 4-element frame limit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_minmax_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid  [3];
    logic        in_last   [3];
    logic        out_ready [3];
    logic [31:0] in_data   [3];
    logic        in_ready  [3];
    logic        out_valid [3];
    logic [31:0] out_min   [3];
    logic [31:0] out_max   [3];
    logic        out_nan   [3];
    logic        out_trunc [3];
    logic [7:0]  min_idx   [3];
    logic [7:0]  max_idx   [3];
    logic [8:0]  count     [3];

    logic [7:0]  w_mi0, w_ma0, w_mi1, w_ma1;
    logic [1:0]  w_mi2, w_ma2;
    logic [8:0]  w_c0, w_c1;
    logic [2:0]  w_c2;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    fp_minmax_stream u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_last(in_last[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_min(out_min[0]), .out_max(out_max[0]),
        .out_min_idx(w_mi0), .out_max_idx(w_ma0), .out_count(w_c0),
        .out_nan(out_nan[0]), .out_trunc(out_trunc[0])
    );

    fp_minmax_stream #(.IEEE_COMPLIANCE(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_last(in_last[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_min(out_min[1]), .out_max(out_max[1]),
        .out_min_idx(w_mi1), .out_max_idx(w_ma1), .out_count(w_c1),
        .out_nan(out_nan[1]), .out_trunc(out_trunc[1])
    );

    fp_minmax_stream #(.MAX_FRAME(4)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .in_last(in_last[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_min(out_min[2]), .out_max(out_max[2]),
        .out_min_idx(w_mi2), .out_max_idx(w_ma2), .out_count(w_c2),
        .out_nan(out_nan[2]), .out_trunc(out_trunc[2])
    );

    always_comb begin
        min_idx[0] = w_mi0;
        min_idx[1] = w_mi1;
        min_idx[2] = {6'b0, w_mi2};
        max_idx[0] = w_ma0;
        max_idx[1] = w_ma1;
        max_idx[2] = {6'b0, w_ma2};
        count[0]   = w_c0;
        count[1]   = w_c1;
        count[2]   = {6'b0, w_c2};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_rec(input int k, input string t,
                           input logic [31:0] mn, input logic [31:0] mi,
                           input logic [31:0] mx, input logic [31:0] ma,
                           input logic [31:0] cnt, input logic [31:0] nan,
                           input logic [31:0] tr);
        chk({t, ".valid"},    32'(out_valid[k]), 1);
        chk({t, ".in_ready"}, 32'(in_ready[k]),  0);
        chk({t, ".min"},      out_min[k],        mn);
        chk({t, ".min_idx"},  32'(min_idx[k]),   mi);
        chk({t, ".max"},      out_max[k],        mx);
        chk({t, ".max_idx"},  32'(max_idx[k]),   ma);
        chk({t, ".count"},    32'(count[k]),     cnt);
        chk({t, ".nan"},      32'(out_nan[k]),   nan);
        chk({t, ".trunc"},    32'(out_trunc[k]), tr);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int k, input logic [31:0] d, input logic last);
        chk("send.in_ready", 32'(in_ready[k]), 1);
        in_valid[k] = 1'b1;
        in_data[k]  = d;
        in_last[k]  = last;
        cycle();
        in_valid[k] = 1'b0;
        in_last[k]  = 1'b0;
    endtask

    task automatic ack(input int k);
        out_ready[k] = 1'b1;
        cycle();
        out_ready[k] = 1'b0;
        chk("ack.valid",    32'(out_valid[k]), 0);
        chk("ack.in_ready", 32'(in_ready[k]),  1);
        chk("ack.count",    32'(count[k]),     0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            in_last[k]   = 1'b0;
            out_ready[k] = 1'b0;
            in_data[k]   = '0;
        end
        repeat (3) cycle();
        rst = 1'b0;

        chk("reset.in_ready", 32'(in_ready[0]),  1);
        chk("reset.valid",    32'(out_valid[0]), 0);
        chk("reset.min",      out_min[0],        0);
        chk("reset.max",      out_max[0],        0);
        chk("reset.count",    32'(count[0]),     0);
        chk("reset.trunc",    32'(out_trunc[2]), 0);

        // Mixed-sign frame, then hold the record under backpressure.
        send(0, 32'h3F800000, 1'b0);
        send(0, 32'hC0000000, 1'b0);
        send(0, 32'h40600000, 1'b1);
        chk_rec(0, "mixed", 32'hC0000000, 1, 32'h40600000, 2, 3, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("hold.valid",    32'(out_valid[0]), 1);
            chk("hold.in_ready", 32'(in_ready[0]),  0);
            chk("hold.min",      out_min[0],        32'hC0000000);
            chk("hold.max",      out_max[0],        32'h40600000);
        end
        ack(0);

        send(0, 32'h80000000, 1'b0);
        send(0, 32'h00000000, 1'b0);
        send(0, 32'h00000000, 1'b1);
        chk_rec(0, "zeros", 32'h80000000, 0, 32'h80000000, 0, 3, 0, 0);
        ack(0);

        send(1, 32'h7FC00000, 1'b0);
        send(1, 32'h00000001, 1'b0);
        send(1, 32'hBF800000, 1'b1);
        chk_rec(1, "ieee1", 32'hBF800000, 2, 32'h00000001, 1, 3, 1, 0);
        ack(1);

        send(0, 32'h7FC00000, 1'b0);
        send(0, 32'h00000001, 1'b0);
        send(0, 32'hBF800000, 1'b1);
        chk_rec(0, "ieee0", 32'hBF800000, 2, 32'h7FC00000, 0, 3, 0, 0);
        ack(0);

        // Truncation at the 4-element limit with a fifth element waiting.
        send(2, 32'h40000000, 1'b0);
        send(2, 32'hC0400000, 1'b0);
        send(2, 32'h3F000000, 1'b0);
        send(2, 32'h40A00000, 1'b0);
        chk_rec(2, "trunc", 32'hC0400000, 1, 32'h40A00000, 3, 4, 0, 1);
        in_valid[2] = 1'b1;
        in_data[2]  = 32'hBF800000;
        in_last[2]  = 1'b1;
        repeat (3) cycle();
        chk("stall.in_ready", 32'(in_ready[2]), 0);
        chk("stall.count",    32'(count[2]),    4);
        chk("stall.min",      out_min[2],       32'hC0400000);
        out_ready[2] = 1'b1;
        cycle();
        out_ready[2] = 1'b0;
        chk("bubble.valid",    32'(out_valid[2]), 0);
        chk("bubble.in_ready", 32'(in_ready[2]),  1);
        cycle();
        in_valid[2] = 1'b0;
        in_last[2]  = 1'b0;
        chk_rec(2, "fifth", 32'hBF800000, 0, 32'hBF800000, 0, 1, 0, 0);
        ack(2);

        send(2, 32'h3F800000, 1'b0);
        send(2, 32'h40000000, 1'b0);
        send(2, 32'hBF800000, 1'b0);
        send(2, 32'h3F800000, 1'b1);
        chk_rec(2, "full_last", 32'hBF800000, 2, 32'h40000000, 1, 4, 0, 0);
        ack(2);

        // Reset mid-frame discards the partial frame.
        send(0, 32'h40400000, 1'b0);
        send(0, 32'hC1000000, 1'b0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_mid.valid",    32'(out_valid[0]), 0);
        chk("rst_mid.in_ready", 32'(in_ready[0]),  1);
        chk("rst_mid.min",      out_min[0],        0);
        chk("rst_mid.max",      out_max[0],        0);
        chk("rst_mid.count",    32'(count[0]),     0);
        send(0, 32'h40000000, 1'b1);
        chk_rec(0, "single", 32'h40000000, 0, 32'h40000000, 0, 1, 0, 0);
        ack(0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule : tb_fp_minmax_stream
`default_nettype wire
